// File: rtl/sid_write_sequencer.sv
// Two-master arbiter and strobe sequencer for the tt_um_sid register write port.
// Round-robin grant with optional burst lock; outputs registered except req_ready.
module sid_write_sequencer #(
  parameter int SETUP_CYC  = 1,
  parameter int STROBE_CYC = 2,
  parameter int HOLD_CYC   = 1,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req_valid,
  input  logic [1:0]       req_lock,
  input  logic [5:0]       req_addr,
  input  logic [3:0]       req_voice,
  input  logic [15:0]      req_data,
  output logic [1:0]       req_ready,
  output logic [7:0]       bus_ctrl,
  output logic [7:0]       bus_data,
  output logic             busy,
  output logic             owner,
  output logic [CNT_W-1:0] wr_count
);

  localparam int CNT_MAX = (SETUP_CYC > STROBE_CYC) ?
                           ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC) :
                           ((STROBE_CYC > HOLD_CYC) ? STROBE_CYC : HOLD_CYC);
  localparam int TW = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  state_t           state_q, state_d;
  logic [TW-1:0]    cnt_q, cnt_d;
  logic             lock_q, lock_d;
  logic             prio_q, prio_d;
  logic             owner_q, owner_d;
  logic             busy_q, busy_d;
  logic [7:0]       bus_ctrl_q, bus_ctrl_d;
  logic [7:0]       bus_data_q, bus_data_d;
  logic [CNT_W-1:0] wr_count_q, wr_count_d;

  logic       grant_v;
  logic       grant_idx;
  logic [2:0] g_addr;
  logic [1:0] g_voice;
  logic [7:0] g_data;
  logic       g_lock;

  // A live lock on a still-valid owner beats the round-robin pointer.
  always_comb begin
    grant_v   = 1'b0;
    grant_idx = prio_q;
    if (!rst && state_q == IDLE && req_valid != 2'b00) begin
      grant_v = 1'b1;
      if (lock_q && req_valid[owner_q]) grant_idx = owner_q;
      else if (req_valid == 2'b11)      grant_idx = prio_q;
      else                              grant_idx = req_valid[1];
    end
  end

  assign req_ready = grant_v ? (grant_idx ? 2'b10 : 2'b01) : 2'b00;
  assign g_addr    = grant_idx ? req_addr[5:3]   : req_addr[2:0];
  assign g_voice   = grant_idx ? req_voice[3:2]  : req_voice[1:0];
  assign g_data    = grant_idx ? req_data[15:8]  : req_data[7:0];
  assign g_lock    = req_lock[grant_idx];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    lock_d     = lock_q;
    prio_d     = prio_q;
    owner_d    = owner_q;
    bus_ctrl_d = bus_ctrl_q;
    bus_data_d = bus_data_q;
    wr_count_d = wr_count_q;
    case (state_q)
      IDLE: begin
        bus_ctrl_d = 8'h00;
        if (lock_q && !req_valid[owner_q]) lock_d = 1'b0;
        if (grant_v) begin
          bus_ctrl_d = {3'b000, g_voice, g_addr};
          bus_data_d = g_data;
          lock_d     = g_lock;
          owner_d    = grant_idx;
          prio_d     = ~grant_idx;
          state_d    = SETUP;
          cnt_d      = TW'(SETUP_CYC - 1);
        end
      end
      SETUP: begin
        if (cnt_q == '0) begin
          state_d       = STROBE;
          cnt_d         = TW'(STROBE_CYC - 1);
          bus_ctrl_d[7] = 1'b1;
        end else begin
          cnt_d = cnt_q - TW'(1);
        end
      end
      STROBE: begin
        if (cnt_q == '0) begin
          state_d       = HOLD;
          cnt_d         = TW'(HOLD_CYC - 1);
          bus_ctrl_d[7] = 1'b0;
        end else begin
          cnt_d = cnt_q - TW'(1);
        end
      end
      HOLD: begin
        if (cnt_q == '0) begin
          state_d    = IDLE;
          bus_ctrl_d = 8'h00;
          wr_count_d = wr_count_q + CNT_W'(1);
        end else begin
          cnt_d = cnt_q - TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      lock_q     <= 1'b0;
      prio_q     <= 1'b0;
      owner_q    <= 1'b0;
      busy_q     <= 1'b0;
      bus_ctrl_q <= 8'h00;
      bus_data_q <= 8'h00;
      wr_count_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      lock_q     <= lock_d;
      prio_q     <= prio_d;
      owner_q    <= owner_d;
      busy_q     <= busy_d;
      bus_ctrl_q <= bus_ctrl_d;
      bus_data_q <= bus_data_d;
      wr_count_q <= wr_count_d;
    end
  end

  assign bus_ctrl = bus_ctrl_q;
  assign bus_data = bus_data_q;
  assign busy     = busy_q;
  assign owner    = owner_q;
  assign wr_count = wr_count_q;

endmodule

// File: tb/tb_sid_write_sequencer.sv
// Directed bench for sid_write_sequencer: default-parameter instance plus a
// second instance with stretched setup/strobe/hold timing.
module tb_sid_write_sequencer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // default instance
  logic [1:0]  req_valid, req_lock;
  logic [2:0]  a0, a1;
  logic [1:0]  v0, v1;
  logic [7:0]  d0, d1;
  logic [1:0]  req_ready;
  logic [7:0]  bus_ctrl, bus_data;
  logic        busy, owner;
  logic [15:0] wr_count;

  // stretched-timing instance
  logic [1:0]  s_valid, s_lock;
  logic [5:0]  s_addr;
  logic [3:0]  s_voice;
  logic [15:0] s_data;
  logic [1:0]  s_ready;
  logic [7:0]  s_ctrl, s_bdata;
  logic        s_busy, s_owner;
  logic [15:0] s_count;

  sid_write_sequencer dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_lock(req_lock),
    .req_addr({a1, a0}), .req_voice({v1, v0}), .req_data({d1, d0}),
    .req_ready(req_ready), .bus_ctrl(bus_ctrl), .bus_data(bus_data),
    .busy(busy), .owner(owner), .wr_count(wr_count)
  );

  sid_write_sequencer #(.SETUP_CYC(2), .STROBE_CYC(3), .HOLD_CYC(2), .CNT_W(16)) dut_s (
    .clk(clk), .rst(rst),
    .req_valid(s_valid), .req_lock(s_lock),
    .req_addr(s_addr), .req_voice(s_voice), .req_data(s_data),
    .req_ready(s_ready), .bus_ctrl(s_ctrl), .bus_data(s_bdata),
    .busy(s_busy), .owner(s_owner), .wr_count(s_count)
  );

  int          tests_run = 0;
  int          fails = 0;
  int          ncyc = 0;
  logic        sp = 1'b0;
  logic [15:0] exp_q[$];
  logic [1:0]  g;
  int          gc[4];
  int          sg[2];
  logic [7:0]  tr_ctrl [5] = '{8'h00, 8'h80, 8'h80, 8'h00, 8'h00};
  logic        tr_busy [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge; each strobe rise pops the scoreboard.
  task automatic tick();
    logic [15:0] e;
    @(negedge clk);
    ncyc++;
    if (!rst && bus_ctrl[7] && !sp) begin
      chk("sb_pending", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("sb_bus_word", {bus_ctrl, bus_data}, e);
      end
    end
    sp = bus_ctrl[7];
  endtask

  task automatic wait_grant(output logic [1:0] gr);
    gr = 2'b00;
    for (int i = 0; i < 30 && gr == 2'b00; i++) begin
      #1;
      if (req_ready != 2'b00) gr = req_ready;
      else tick();
    end
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 30; i++) begin
      tick();
      if (!busy) break;
    end
    chk(tag, busy, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1);
  end

  initial begin
    int ng, rises, hi1, rise_n;
    logic sp1;
    rst = 1'b1;
    req_valid = 2'b01; req_lock = 2'b00;
    a0 = 3'd5; a1 = 3'd0; v0 = 2'd1; v1 = 2'd0; d0 = 8'h5A; d1 = 8'h00;
    s_valid = 2'b01; s_lock = 2'b00; s_addr = 6'h00; s_voice = 4'h0; s_data = 16'h0;
    tick();
    tick();
    // reset state, with requests pending so req_ready gating is exercised
    chk("rst_bus_ctrl", bus_ctrl, 8'h00);
    chk("rst_bus_data", bus_data, 8'h00);
    chk("rst_req_ready", req_ready, 2'b00);
    chk("rst_busy", busy, 0);
    chk("rst_owner", owner, 0);
    chk("rst_wr_count", wr_count, 0);
    chk("rst_s_ready", s_ready, 2'b00);
    chk("rst_s_busy", s_busy, 0);
    req_valid = 2'b00; s_valid = 2'b00;
    tick();
    rst = 1'b0;
    tick();

    // single write, cycle-accurate trace
    exp_q.push_back(16'h8024);
    a0 = 3'd0; v0 = 2'd0; d0 = 8'h24; req_lock = 2'b00; req_valid = 2'b01;
    #1 chk("w1_ready", req_ready, 2'b01);
    tick();
    req_valid = 2'b00; d0 = 8'hFF;
    chk("w1_data_setup", bus_data, 8'h24);
    chk("w1_ready_pulse", req_ready, 2'b00);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) tick();
      chk("w1_ctrl", bus_ctrl, tr_ctrl[i]);
      chk("w1_busy", busy, tr_busy[i]);
    end
    chk("w1_count", wr_count, 1);

    // filter/global voice from req1
    exp_q.push_back(16'h9B0F);
    a1 = 3'd3; v1 = 2'd3; d1 = 8'h0F; req_valid = 2'b10;
    wait_grant(g);
    chk("flt_grant", g, 2'b10);
    tick();
    req_valid = 2'b00;
    chk("flt_owner", owner, 1);
    wait_idle("flt_idle");
    chk("flt_count", wr_count, 2);

    // round-robin with both requesters held valid
    for (int k = 0; k < 2; k++) begin
      exp_q.push_back(16'h8A11);
      exp_q.push_back(16'h9522);
    end
    a0 = 3'd2; v0 = 2'd1; d0 = 8'h11;
    a1 = 3'd5; v1 = 2'd2; d1 = 8'h22;
    req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      wait_grant(g);
      chk("rr_grant", g, (k % 2 == 1) ? 2'b10 : 2'b01);
      gc[k] = ncyc;
      tick();
    end
    req_valid = 2'b00;
    for (int k = 1; k < 4; k++) chk("rr_spacing", gc[k] - gc[k-1], 5);
    wait_idle("rr_idle");
    chk("rr_count", wr_count, 6);

    // burst lock: freq lo then freq hi from req0 before req1 gets in
    exp_q.push_back(16'h8034);
    exp_q.push_back(16'h8112);
    exp_q.push_back(16'h975A);
    a0 = 3'd0; v0 = 2'd0; d0 = 8'h34; req_lock = 2'b01;
    a1 = 3'd7; v1 = 2'd2; d1 = 8'h5A;
    req_valid = 2'b11;
    wait_grant(g);
    chk("bl_first", g, 2'b01);
    tick();
    a0 = 3'd1; d0 = 8'h12; req_lock = 2'b00;
    wait_grant(g);
    chk("bl_locked", g, 2'b01);
    tick();
    req_valid = 2'b10;
    wait_grant(g);
    chk("bl_other", g, 2'b10);
    tick();
    req_valid = 2'b00;
    wait_idle("bl_idle");
    chk("bl_count", wr_count, 9);

    // reset in the middle of a strobe
    exp_q.push_back(16'h8C77);
    a0 = 3'd4; v0 = 2'd1; d0 = 8'h77; req_valid = 2'b01;
    wait_grant(g);
    chk("mr_grant", g, 2'b01);
    tick();
    req_valid = 2'b00;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus_ctrl[7]) break;
    end
    chk("mr_strobe_seen", bus_ctrl[7], 1);
    #1 rst = 1'b1;
    #1;
    chk("mr_ctrl_async", bus_ctrl, 8'h00);
    chk("mr_busy", busy, 0);
    chk("mr_count_kept", wr_count, 0);
    tick();
    rst = 1'b0;
    exp_q.push_back(16'h86C3);
    a0 = 3'd6; v0 = 2'd0; d0 = 8'hC3;
    a1 = 3'd1; v1 = 2'd1; d1 = 8'h3C;
    req_valid = 2'b11;
    wait_grant(g);
    chk("mr_after_grant", g, 2'b01);
    tick();
    req_valid = 2'b00;
    wait_idle("mr_idle");
    chk("mr_after_count", wr_count, 1);

    // stretched timing instance: two back-to-back writes from req0
    s_addr = 6'o02; s_voice = 4'b0011; s_data = 16'h00A5; s_lock = 2'b00;
    s_valid = 2'b01;
    ng = 0; rises = 0; hi1 = 0; rise_n = 0; sp1 = 1'b0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (ng < 2 && s_ready != 2'b00) begin
        sg[ng] = ncyc;
        ng++;
      end
      tick();
      if (ng == 2) s_valid = 2'b00;
      if (s_ctrl[7] && !sp1) begin
        rises++;
        if (rises == 1) begin
          rise_n = ncyc;
          chk("sw_bus_word", {s_ctrl, s_bdata}, 16'h9AA5);
        end
      end
      if (s_ctrl[7] && rises == 1) hi1++;
      sp1 = s_ctrl[7];
    end
    chk("sw_grants", ng, 2);
    chk("sw_setup_lat", rise_n - sg[0], 3);
    chk("sw_strobe_len", hi1, 3);
    chk("sw_spacing", sg[1] - sg[0], 8);
    chk("sw_count", s_count, 2);
    chk("sw_owner", s_owner, 0);
    chk("sw_idle", s_busy, 0);

    chk("sb_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
